// File: rtl/param_decrement_counter_pkg.sv
// -----------------------------------------------------------------------------
// param_decrement_counter_pkg
// Shared definitions for the parameterised decrement counter:
//   DEFAULT_WIDTH : default count width in bits
//   state_e       : two-state control FSM encoding (IDLE, RUN)
//   is_all_zero   : helper that reports whether a count value is zero
// -----------------------------------------------------------------------------
package param_decrement_counter_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Zero detection on a count of up to 32 bits; the caller zero-extends.
  function automatic logic is_all_zero(input logic [31:0] value);
    return (value == 32'd0);
  endfunction

endpackage

// File: rtl/param_decrement_counter_dec_core.sv
// -----------------------------------------------------------------------------
// dec_core
// Purely combinational ripple decrement-by-one.
// Ports:
//   a      : input  [WIDTH-1:0] operand
//   diff   : output [WIDTH-1:0] (a - 1) modulo 2^WIDTH
//   borrow : output             borrow out of the MSB; high only when a == 0
// -----------------------------------------------------------------------------
module dec_core
  import param_decrement_counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  logic chain_s;

  // Ripple the borrow from LSB to MSB; subtracting one injects a borrow at bit 0.
  always_comb begin
    diff    = {WIDTH{1'b0}};
    chain_s = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      diff[i] = a[i] ^ chain_s;
      chain_s = (~a[i]) & chain_s;
    end
    borrow = chain_s;
  end

endmodule

// File: rtl/param_decrement_counter.sv
// -----------------------------------------------------------------------------
// param_decrement_counter
// Loadable down-counter with selectable underflow handling.
// Optional feature macro: PARAM_DECREMENT_COUNTER_AUTO_RELOAD_EN
//   defined   -> a wrapping underflow (sat=0) reloads the last loaded value
//   undefined -> a wrapping underflow goes to all ones; no reload storage
// Ports:
//   clk        : in  clock, all state changes on rising edge
//   rst_n      : in  synchronous active-low reset (priority over everything)
//   load       : in  capture load_val into count (and reload register), go RUN
//   load_val   : in  [WIDTH-1:0] start / reload value
//   en         : in  decrement enable, only acts in RUN
//   sat        : in  underflow mode: 1 = saturate at zero and stop, 0 = wrap
//   count      : out [WIDTH-1:0] registered count
//   zero       : out high while count == 0
//   borrow_out : out one-cycle registered underflow pulse
//   busy       : out high while the FSM is in RUN
// WIDTH legal range is 2..32.
// -----------------------------------------------------------------------------
module param_decrement_counter
  import param_decrement_counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             sat,
  output logic [WIDTH-1:0] count,
  output logic             zero,
  output logic             borrow_out,
  output logic             busy
);

  state_e           state_q,  state_d;
  logic [WIDTH-1:0] count_q,  count_d;
  logic             borrow_q, borrow_d;
  logic             zero_q,   zero_d;
  logic             busy_q,   busy_d;
`ifdef PARAM_DECREMENT_COUNTER_AUTO_RELOAD_EN
  logic [WIDTH-1:0] reload_q, reload_d;
`endif

  logic [WIDTH-1:0] dec_diff_s;
  logic             dec_borrow_s;

  dec_core #(
    .WIDTH (WIDTH)
  ) u_dec_core (
    .a      (count_q),
    .diff   (dec_diff_s),
    .borrow (dec_borrow_s)
  );

  // Next-state, next-count and flag computation.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    borrow_d = 1'b0;
`ifdef PARAM_DECREMENT_COUNTER_AUTO_RELOAD_EN
    reload_d = reload_q;
`endif
    if (load) begin
      // Load wins over any coincident underflow, so no borrow pulse here.
      count_d = load_val;
      state_d = RUN;
`ifdef PARAM_DECREMENT_COUNTER_AUTO_RELOAD_EN
      reload_d = load_val;
`endif
    end else begin
      case (state_q)
        RUN: begin
          if (en) begin
            // The MSB borrow of the decrementer is the underflow indication.
            if (dec_borrow_s) begin
              borrow_d = 1'b1;
              if (sat) begin
                count_d = {WIDTH{1'b0}};
                state_d = IDLE;
              end else begin
`ifdef PARAM_DECREMENT_COUNTER_AUTO_RELOAD_EN
                count_d = reload_q;
`else
                count_d = dec_diff_s;
`endif
                state_d = RUN;
              end
            end else begin
              count_d = dec_diff_s;
              state_d = RUN;
            end
          end else begin
            count_d = count_q;
            state_d = RUN;
          end
        end
        IDLE: begin
          count_d = count_q;
          state_d = IDLE;
        end
        default: begin
          count_d = count_q;
          state_d = IDLE;
        end
      endcase
    end
    // Flags are registered from the next-state values so they line up with count.
    zero_d = is_all_zero(32'(count_d));
    busy_d = (state_d == RUN);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      count_q  <= {WIDTH{1'b0}};
      borrow_q <= 1'b0;
      zero_q   <= 1'b1;
      busy_q   <= 1'b0;
`ifdef PARAM_DECREMENT_COUNTER_AUTO_RELOAD_EN
      reload_q <= {WIDTH{1'b0}};
`endif
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      borrow_q <= borrow_d;
      zero_q   <= zero_d;
      busy_q   <= busy_d;
`ifdef PARAM_DECREMENT_COUNTER_AUTO_RELOAD_EN
      reload_q <= reload_d;
`endif
    end
  end

  assign count      = count_q;
  assign zero       = zero_q;
  assign borrow_out = borrow_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_param_decrement_counter.sv
// -----------------------------------------------------------------------------
// tb_param_decrement_counter
// Scoreboard bench for param_decrement_counter (WIDTH=4). Each stimulus step
// pushes the expected post-edge outputs; a monitor pops and compares them
// shortly after every rising edge.
// -----------------------------------------------------------------------------
module tb_param_decrement_counter;

  localparam int WIDTH = 4;

  typedef struct {
    logic [WIDTH-1:0] count;
    logic             zero;
    logic             borrow;
    logic             busy;
    string            name;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             load = 1'b0;
  logic [WIDTH-1:0] load_val = 4'd0;
  logic             en = 1'b0;
  logic             sat = 1'b0;
  logic [WIDTH-1:0] count;
  logic             zero;
  logic             borrow_out;
  logic             busy;

  exp_t exp_q[$];
  int   tests_run = 0;
  int   tests_failed = 0;

  param_decrement_counter #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .load_val   (load_val),
    .en         (en),
    .sat        (sat),
    .count      (count),
    .zero       (zero),
    .borrow_out (borrow_out),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs and queue the outputs expected after the edge.
  task automatic step(input logic r, input logic l, input logic [WIDTH-1:0] v,
                      input logic e, input logic s, input logic [WIDTH-1:0] ec,
                      input logic eb, input logic ebusy, input string nm);
    exp_t x;
    @(negedge clk);
    rst_n = r; load = l; load_val = v; en = e; sat = s;
    @(posedge clk);
    x.count  = ec;
    x.zero   = (ec == 4'd0);
    x.borrow = eb;
    x.busy   = ebusy;
    x.name   = nm;
    exp_q.push_back(x);
  endtask

  // Monitor: compare registered outputs just after every rising edge.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        tests_run++;
        if (count !== x.count || zero !== x.zero || borrow_out !== x.borrow || busy !== x.busy) begin
          tests_failed++;
          $display("FAIL %s: got count=%0d zero=%0b borrow=%0b busy=%0b, want count=%0d zero=%0b borrow=%0b busy=%0b",
                   x.name, count, zero, borrow_out, busy, x.count, x.zero, x.borrow, x.busy);
        end
      end
    end
  end

  // Watchdog so the run can never hang.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    //    rst load val  en   sat  count b    busy
    step(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, "reset0");
    step(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, "reset1");

    // Countdown with wrap.
    step(1'b1, 1'b1, 4'd3, 1'b1, 1'b0, 4'd3, 1'b0, 1'b1, "cd_load3");
    step(1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 4'd2, 1'b0, 1'b1, "cd_2");
    step(1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 4'd1, 1'b0, 1'b1, "cd_1");
    step(1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, "cd_0");
`ifdef PARAM_DECREMENT_COUNTER_AUTO_RELOAD_EN
    step(1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 4'd3, 1'b1, 1'b1, "cd_reload");
    step(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 4'd3, 1'b0, 1'b1, "cd_hold");
`else
    step(1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 4'd15, 1'b1, 1'b1, "cd_wrap");
    step(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 4'd15, 1'b0, 1'b1, "cd_hold");
`endif

    // Saturate: stop at zero and drop to IDLE with the pulse.
    step(1'b1, 1'b1, 4'd1, 1'b1, 1'b1, 4'd1, 1'b0, 1'b1, "sat_load1");
    step(1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b1, "sat_0");
    step(1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 4'd0, 1'b1, 1'b0, "sat_under");
    step(1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, "sat_idle");

    // Repeated underflow with load 2.
    step(1'b1, 1'b1, 4'd2, 1'b1, 1'b0, 4'd2, 1'b0, 1'b1, "ar_load2");
    step(1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 4'd1, 1'b0, 1'b1, "ar_1");
    step(1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, "ar_0");
`ifdef PARAM_DECREMENT_COUNTER_AUTO_RELOAD_EN
    step(1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 4'd2, 1'b1, 1'b1, "ar_reload_a");
    step(1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 4'd1, 1'b0, 1'b1, "ar_1b");
    step(1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, "ar_0b");
    step(1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 4'd2, 1'b1, 1'b1, "ar_reload_b");
`else
    step(1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 4'd15, 1'b1, 1'b1, "ar_wrap");
    step(1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 4'd14, 1'b0, 1'b1, "ar_14");
`endif

    // Enable gating.
    step(1'b1, 1'b1, 4'd9, 1'b1, 1'b0, 4'd9, 1'b0, 1'b1, "en_load9");
    step(1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 4'd8, 1'b0, 1'b1, "en_on");
    step(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 4'd8, 1'b0, 1'b1, "en_off");
    step(1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 4'd7, 1'b0, 1'b1, "en_on2");

    // Load coinciding with underflow.
    step(1'b1, 1'b1, 4'd1, 1'b1, 1'b0, 4'd1, 1'b0, 1'b1, "col_load1");
    step(1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, "col_0");
    step(1'b1, 1'b1, 4'd5, 1'b1, 1'b0, 4'd5, 1'b0, 1'b1, "col_load5");

    // Mid-run reset, then hold until the next load.
    step(1'b1, 1'b1, 4'd7, 1'b1, 1'b0, 4'd7, 1'b0, 1'b1, "mr_load7");
    step(1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 4'd6, 1'b0, 1'b1, "mr_6");
    step(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, "mr_reset");
    step(1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, "mr_hold1");
    step(1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, "mr_hold2");

    // Reset beats load.
    step(1'b0, 1'b1, 4'd5, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, "rst_over_load");

    // Loading zero: RUN with count 0, next enabled cycle underflows.
    step(1'b1, 1'b1, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, "z_load0");
`ifdef PARAM_DECREMENT_COUNTER_AUTO_RELOAD_EN
    step(1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b1, "z_reload");
`else
    step(1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 4'd15, 1'b1, 1'b1, "z_wrap");
    step(1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 4'd14, 1'b0, 1'b1, "z_14");
`endif
    step(1'b1, 1'b1, 4'd0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b1, "zs_load0");
    step(1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 4'd0, 1'b1, 1'b0, "zs_under");

    // Let the monitor drain, bounded by a cycle budget.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
      @(posedge clk);
      #2;
    end
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/param_decrement_counter.md
PARAM_DECREMENT_COUNTER -- requirements
Module: param_decrement_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the count width in bits (legal range 2..32).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, synchronous active-low reset sampled on rising clk.
REQ-004 SHALL have port load, input, 1, which captures load_val into the count and the reload register.
REQ-005 SHALL have port load_val, input, WIDTH, the start/reload value.
REQ-006 SHALL have port en, input, 1, the decrement enable, effective only in RUN.
REQ-007 SHALL have port sat, input, 1, selecting underflow mode: 1 = saturate at zero, 0 = wrap.
REQ-008 SHALL have port count, output, WIDTH, the registered current count.
REQ-009 SHALL have port zero, output, 1, high whenever count equals 0.
REQ-010 SHALL have port borrow_out, output, 1, a registered one-cycle underflow pulse.
REQ-011 SHALL have port busy, output, 1, high while the FSM is in RUN.

Function
REQ-012 SHALL implement a two-state FSM: IDLE and RUN.
REQ-013 SHALL treat load=1 in any state as highest priority: next count = load_val, reload register = load_val, next state RUN, borrow_out = 0.
REQ-014 SHALL decrement count by exactly 1 per cycle when in RUN, en=1, load=0 and count != 0; result appears one cycle later.
REQ-015 SHALL hold count when en=0, or when in IDLE without load.
REQ-016 SHALL treat count == 0 with en=1 in RUN as underflow: assert borrow_out for exactly the next cycle.
REQ-017 SHALL, on underflow with sat=0 and the auto-reload feature absent, set count to all ones (2^WIDTH-1) and remain in RUN.
REQ-018 SHALL, on underflow with sat=1, hold count at 0 and transition to IDLE (busy=0 next cycle).
REQ-019 SHALL enter RUN with count 0 when load_val=0 is loaded, so the next enabled cycle underflows.
REQ-020 SHALL, when load and underflow coincide, apply the load and suppress borrow_out.
REQ-021 SHALL compute the decrement modulo 2^WIDTH, using the borrow from the MSB as the underflow indication.

Reset
REQ-022 SHALL, on a clk edge with rst_n=0, set count=0, reload register=0, borrow_out=0 and state=IDLE, with busy=0 and zero=1.
REQ-023 SHALL give reset priority over load and en, including when reset is asserted mid-count.

Configuration
REQ-024 SHALL, when macro PARAM_DECREMENT_COUNTER_AUTO_RELOAD_EN is defined, reload count from the reload register on a sat=0 underflow, instead of wrapping, and remain in RUN.
REQ-025 SHALL, when PARAM_DECREMENT_COUNTER_AUTO_RELOAD_EN is undefined, have no reload register storage and follow REQ-017; sat=1 behaviour is identical with or without the macro.

Structure
REQ-026 SHALL place the FSM state enum (IDLE, RUN) and DEFAULT_WIDTH=4 in shared package param_decrement_counter_pkg.
REQ-027 SHALL instantiate one combinational sub-module, dec_core (WIDTH-parameterised ripple decrement with diff and borrow outputs), for the arithmetic.

Verification
REQ-028 SHALL verify countdown (WIDTH=4): load 4'd3, en=1, sat=0 -> count 3,2,1,0,15; borrow_out high only in the cycle count shows 15; busy stays 1.
REQ-029 SHALL verify saturate: load 4'd1, en=1, sat=1 -> count 1,0,0; one borrow_out pulse; busy falls with the pulse; zero=1.
REQ-030 SHALL verify auto-reload (macro defined): load 4'd2, en=1, sat=0 -> count 2,1,0,2,1,0,2; borrow_out pulses every third cycle.
REQ-031 SHALL verify enable gating: load 4'd9, en toggling 1,0,1 -> count 9,8,8,7.
REQ-032 SHALL verify collision: count=0, en=1 with load=1, load_val=4'd5 -> count 5, borrow_out 0.
REQ-033 SHALL verify mid-run reset: count at 6 in RUN, rst_n=0 for one cycle -> count 0, busy 0, zero 1, borrow_out 0; count holds after rst_n=1 until the next load.
